// File: rtl/panel_pkg.sv
// Shared definitions for the panel programmer: default parameter values and
// the programming FSM state encoding.
package panel_pkg;

  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_ADDR_W       = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 4;
  localparam int unsigned DEF_WRAP         = 0;

  typedef enum logic [2:0] {
    S_RUN,
    S_IDLE,
    S_PRESS,
    S_WRITE,
    S_RELEASE
  } panel_state_t;

endpackage

// File: rtl/panel_programmer_if.sv
// Program-memory write bus driven by the panel programmer.
//   mem_we    : one-cycle write strobe
//   mem_addr  : write address (programmer's pointer)
//   mem_wdata : write data
// master = programmer side, slave = memory side.
interface panel_programmer_if
  import panel_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);

endinterface

// File: rtl/panel_debounce.sv
// Two-flop synchroniser followed by a debouncer for one asynchronous,
// possibly bouncy level input.
//   clock, reset_N : system clock, async active-low reset
//   din            : raw asynchronous input
//   level          : debounced level; changes only after the synchronised
//                    input has differed from it for DEBOUNCE_CYC cycles
module panel_debounce
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter bit          RESET_LEVEL  = 1'b0
) (
  input  logic clock,
  input  logic reset_N,
  input  logic din,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      level <= RESET_LEVEL;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Any cycle where the input agrees with the accepted level restarts
      // the run; the level flips on the last cycle of an unbroken run.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/panel_programmer.sv
// Front-panel program loader: in program mode each debounced button press
// writes the switch word to the next program-memory address; in run mode the
// CPU core is released from reset.
//   clock, reset_N : system clock, async active-low reset
//   mode           : slide switch, 1 = program, 0 = run (async)
//   prog_btn_N     : program button, 0 = pressed (async, bouncy)
//   addr_clr       : clear pointer and word count (honoured when idle)
//   data_in        : word from slide switches
//   mem            : program-memory write bus (master)
//   cpu_reset_N    : active-low CPU reset, released only while running
//   full           : DEPTH words written
//   word_count     : words written since last clear, saturating at DEPTH
//   last_data      : most recently written word
module panel_programmer
  import panel_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned WRAP         = DEF_WRAP
) (
  input  logic                clock,
  input  logic                reset_N,
  input  logic                mode,
  input  logic                prog_btn_N,
  input  logic                addr_clr,
  input  logic [DATA_W-1:0]   data_in,
  panel_programmer_if.master  mem,
  output logic                cpu_reset_N,
  output logic                full,
  output logic [ADDR_W:0]     word_count,
  output logic [DATA_W-1:0]   last_data
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic mode_db, mode_db_q;
  logic btn_db, btn_db_q;
  logic mode_rise, mode_fall, btn_fall;
  logic write_blocked;

  panel_state_t      state, next_state;
  logic [ADDR_W-1:0] pointer;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] last_r;
  logic              we_r;
  logic              cpu_r;

  panel_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RESET_LEVEL  (1'b0)
  ) u_mode_db (
    .clock   (clock),
    .reset_N (reset_N),
    .din     (mode),
    .level   (mode_db)
  );

  panel_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RESET_LEVEL  (1'b1)
  ) u_btn_db (
    .clock   (clock),
    .reset_N (reset_N),
    .din     (prog_btn_N),
    .level   (btn_db)
  );

  assign mode_rise     = mode_db & ~mode_db_q;
  assign mode_fall     = ~mode_db & mode_db_q;
  assign btn_fall      = ~btn_db & btn_db_q;
  assign full          = (count == DEPTH_CNT);
  assign write_blocked = full && (WRAP == 0);

  always_comb begin
    next_state = state;
    if (mode_fall) begin
      next_state = S_RUN;
    end else begin
      unique case (state)
        S_RUN:     if (mode_rise) next_state = S_IDLE;
        // Edge, not level: entering idle with the button still held
        // must not start a write.
        S_IDLE:    if (btn_fall) next_state = S_PRESS;
        S_PRESS:   next_state = S_WRITE;
        S_WRITE:   next_state = S_RELEASE;
        S_RELEASE: if (btn_db) next_state = S_IDLE;
        default:   next_state = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state     <= S_RUN;
      mode_db_q <= 1'b0;
      btn_db_q  <= 1'b1;
      pointer   <= '0;
      count     <= '0;
      wdata_r   <= '0;
      last_r    <= '0;
      we_r      <= 1'b0;
      cpu_r     <= 1'b0;
    end else begin
      state     <= next_state;
      mode_db_q <= mode_db;
      btn_db_q  <= btn_db;

      // Strobe registered on entry to S_WRITE so it spans exactly that state.
      we_r  <= (next_state == S_WRITE) && !write_blocked;
      // Held low on the entry cycle so release lags S_RUN entry by one cycle,
      // and dropped together with the state on leaving S_RUN.
      cpu_r <= (state == S_RUN) && (next_state == S_RUN);

      if (state == S_IDLE && next_state == S_PRESS) begin
        wdata_r <= data_in;
      end

      if (state == S_RUN && next_state == S_IDLE) begin
        pointer <= '0;
        count   <= '0;
      end else if (state == S_IDLE && addr_clr) begin
        pointer <= '0;
        count   <= '0;
      end else if (state == S_WRITE && we_r) begin
        pointer <= pointer + 1'b1;
        if (count != DEPTH_CNT) begin
          count <= count + 1'b1;
        end
        last_r <= wdata_r;
      end
    end
  end

  assign mem.mem_we    = we_r;
  assign mem.mem_addr  = pointer;
  assign mem.mem_wdata = wdata_r;
  assign cpu_reset_N   = cpu_r;
  assign word_count    = count;
  assign last_data     = last_r;

endmodule

// File: tb/tb_panel_programmer.sv
module tb_panel_programmer;

  localparam int unsigned D = 4;

  logic       clock = 1'b0;
  logic       reset_N;
  logic       mode;
  logic       prog_btn_N;
  logic       addr_clr;
  logic [7:0] data_in;

  logic       cpu0, full0, cpu1, full1;
  logic [4:0] wc0, wc1;
  logic [7:0] ld0, ld1;

  panel_programmer_if #(.DATA_W(8), .ADDR_W(4)) mem0 ();
  panel_programmer_if #(.DATA_W(8), .ADDR_W(4)) mem1 ();

  panel_programmer #(
    .DATA_W(8), .ADDR_W(4), .DEBOUNCE_CYC(D), .WRAP(0)
  ) dut (
    .clock(clock), .reset_N(reset_N), .mode(mode), .prog_btn_N(prog_btn_N),
    .addr_clr(addr_clr), .data_in(data_in), .mem(mem0),
    .cpu_reset_N(cpu0), .full(full0), .word_count(wc0), .last_data(ld0)
  );

  panel_programmer #(
    .DATA_W(8), .ADDR_W(4), .DEBOUNCE_CYC(D), .WRAP(1)
  ) dut_w (
    .clock(clock), .reset_N(reset_N), .mode(mode), .prog_btn_N(prog_btn_N),
    .addr_clr(addr_clr), .data_in(data_in), .mem(mem1),
    .cpu_reset_N(cpu1), .full(full1), .word_count(wc1), .last_data(ld1)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         passed = 0;
  int         we0 = 0, we1 = 0;
  logic [3:0] addr0, addr1;
  logic [7:0] data0, data1;

  // Write strobes observed mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (mem0.mem_we) begin
      we0++;
      addr0 = mem0.mem_addr;
      data0 = mem0.mem_wdata;
    end
    if (mem1.mem_we) begin
      we1++;
      addr1 = mem1.mem_addr;
      data1 = mem1.mem_wdata;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] addr;
    logic [4:0] count;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_hold(input logic [7:0] d);
    data_in    = d;
    prog_btn_N = 1'b0;
    repeat (12) tick();
    prog_btn_N = 1'b1;
    repeat (12) tick();
  endtask

  int b0, b1;
  bit found;

  initial begin
    vecs[0] = '{data: 8'h01, addr: 4'd0, count: 5'd1};
    vecs[1] = '{data: 8'h04, addr: 4'd1, count: 5'd2};
    vecs[2] = '{data: 8'hC0, addr: 4'd2, count: 5'd3};
    vecs[3] = '{data: 8'h00, addr: 4'd3, count: 5'd4};

    reset_N    = 1'b0;
    mode       = 1'b0;
    prog_btn_N = 1'b1;
    addr_clr   = 1'b0;
    data_in    = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_we", mem0.mem_we, 0);
    check("rst_addr", mem0.mem_addr, 0);
    check("rst_wdata", mem0.mem_wdata, 0);
    check("rst_cpu", cpu0, 0);
    check("rst_wc", wc0, 0);
    check("rst_full", full0, 0);
    check("rst_last", ld0, 0);

    reset_N = 1'b1;
    repeat (3) tick();
    check("run_cpu_released", cpu0, 1);

    // Enter program mode
    mode = 1'b1;
    repeat (12) tick();
    check("prog_cpu_held", cpu0, 0);
    check("prog_wc", wc0, 0);

    // Basic programming sequence
    for (int i = 0; i < 4; i++) begin
      b0 = we0;
      press_hold(vecs[i].data);
      check("vec_we_count", we0 - b0, 1);
      check("vec_addr", addr0, vecs[i].addr);
      check("vec_wdata", data0, vecs[i].data);
      check("vec_wc", wc0, vecs[i].count);
      check("vec_last", ld0, vecs[i].data);
    end
    check("seq_wc", wc0, 4);
    check("seq_last", ld0, 8'h00);
    check("seq_full", full0, 0);

    // Bouncy button yields one write
    b0 = we0;
    data_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      prog_btn_N = 1'b0; tick();
      prog_btn_N = 1'b1; tick();
    end
    prog_btn_N = 1'b0;
    repeat (10) tick();
    prog_btn_N = 1'b1;
    repeat (12) tick();
    check("bounce_we_count", we0 - b0, 1);
    check("bounce_addr", addr0, 4);
    check("bounce_wc", wc0, 5);
    check("bounce_last", ld0, 8'h5A);

    // addr_clr in idle
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    check("clr_wc", wc0, 0);
    check("clr_addr", mem0.mem_addr, 0);
    check("clr_last_kept", ld0, 8'h5A);
    tick();

    // Press latency: held low from edge k, strobe after edge k+3+D
    data_in    = 8'h3C;
    prog_btn_N = 1'b0;
    tick();                        // edge k
    repeat (D + 2) tick();         // edge k+2+D
    check("lat_we_early", mem0.mem_we, 0);
    tick();                        // edge k+3+D
    check("lat_we", mem0.mem_we, 1);
    check("lat_addr", mem0.mem_addr, 0);
    check("lat_last_before", ld0, 8'h5A);
    tick();
    check("lat_we_one_cycle", mem0.mem_we, 0);
    repeat (8) tick();
    prog_btn_N = 1'b1;
    repeat (12) tick();
    check("lat_last_after", ld0, 8'h3C);
    check("lat_wc", wc0, 1);

    // Mode drops while in S_PRESS: abort, release CPU
    b0 = we0;
    data_in    = 8'hEE;
    prog_btn_N = 1'b0;
    tick();                        // edge k
    mode = 1'b0;                   // first sampled at edge k+1
    repeat (D + 3) tick();         // edge k+3+D: S_PRESS -> S_RUN
    check("abort_we", mem0.mem_we, 0);
    check("abort_cpu_entry", cpu0, 0);
    tick();
    check("abort_cpu_released", cpu0, 1);
    prog_btn_N = 1'b1;
    repeat (12) tick();
    check("abort_no_write", we0 - b0, 0);
    check("abort_wc_kept", wc0, 1);
    mode = 1'b1;
    repeat (12) tick();
    check("reenter_wc", wc0, 0);
    check("reenter_cpu", cpu0, 0);

    // Fill memory
    for (int i = 0; i < 16; i++) begin
      b0 = we0;
      press_hold(8'hAA);
      check("fill_we", we0 - b0, 1);
      check("fill_addr", addr0, i);
    end
    check("full_nowrap", full0, 1);
    check("full_wc", wc0, 16);
    check("full_wrap", full1, 1);

    b0 = we0;
    b1 = we1;
    press_hold(8'hAA);
    check("over_nowrap_we", we0 - b0, 0);
    check("over_nowrap_wc", wc0, 16);
    check("over_wrap_we", we1 - b1, 1);
    check("over_wrap_addr", addr1, 0);
    check("over_wrap_full", full1, 1);
    check("over_wrap_wc", wc1, 16);

    // Reset asserted mid S_WRITE
    data_in    = 8'h77;
    prog_btn_N = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (mem1.mem_we) found = 1'b1;
    end
    check("midwrite_reached", found, 1);
    #2;
    reset_N = 1'b0;
    #1;
    check("midrst_we", mem1.mem_we, 0);
    check("midrst_cpu", cpu1, 0);
    check("midrst_wc", wc1, 0);
    check("midrst_full", full1, 0);
    check("midrst_addr", mem1.mem_addr, 0);
    check("midrst_wdata", mem1.mem_wdata, 0);
    check("midrst_last", ld1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
